// File: rtl/s_to_p.sv
// Serial-to-parallel frame collector: N samples of WIDTH bits become one frame, valid 1 clk after the last sample.
// No backpressure: unacked frames are dropped and o_overrun set; S2P_ALIGN_EN enables i_start re-alignment in FILL.
module s_to_p #(
   parameter int WIDTH = 10,
   parameter int N     = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_start,
   input  logic               i_valid,
   input  logic [WIDTH-1:0]   i_data,
   input  logic               i_frame_ack,
   output logic [N*WIDTH-1:0] o_frame,
   output logic               o_frame_valid,
   output logic               o_busy,
   output logic               o_overrun
);

   localparam int IDXW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

   typedef enum logic {IDLE, FILL} state_t;

   state_t             state, state_nxt;
   logic [IDXW-1:0]    idx, idx_nxt, wr_slot;
   logic [N*WIDTH-1:0] frame_buf, buf_nxt;
   logic               fill, wr, at_last, complete, realign;

   always_comb begin
      fill     = (state == FILL);
      wr       = fill && i_valid;
      at_last  = (idx == LAST);
      complete = wr && at_last;
`ifdef S2P_ALIGN_EN
      // A completing sample finishes its frame; idx wraps to 0 anyway, so no realign is needed.
      realign  = fill && i_start && !complete;
`else
      realign  = 1'b0;
`endif
      wr_slot  = realign ? '0 : idx;

      buf_nxt = frame_buf;
      if (wr)
         buf_nxt[int'(wr_slot)*WIDTH +: WIDTH] = i_data;

      idx_nxt = idx;
      if (!fill)
         idx_nxt = '0;
      else if (realign)
         idx_nxt = i_valid ? IDXW'(1) : '0;
      else if (wr)
         idx_nxt = at_last ? '0 : idx + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_start) state_nxt = FILL;
         FILL:    state_nxt = FILL;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_busy = (state == FILL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx           <= '0;
         frame_buf     <= '0;
         o_frame       <= '0;
         o_frame_valid <= 1'b0;
         o_overrun     <= 1'b0;
      end else begin
         idx       <= idx_nxt;
         frame_buf <= buf_nxt;
         if (complete && (!o_frame_valid || i_frame_ack)) begin
            o_frame       <= buf_nxt;
            o_frame_valid <= 1'b1;
         end else if (complete) begin
            o_overrun <= 1'b1;
         end else if (i_frame_ack) begin
            o_frame_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_s_to_p.sv
// Directed bench for s_to_p with WIDTH=10, N=64; expected frames are built from the sample values sent.
module tb_s_to_p;
   localparam int WIDTH = 10;
   localparam int N     = 64;
   localparam int FW    = N * WIDTH;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_start;
   logic          i_valid;
   logic [WIDTH-1:0] i_data;
   logic          i_frame_ack;
   logic [FW-1:0] o_frame;
   logic          o_frame_valid;
   logic          o_busy;
   logic          o_overrun;

   int vectors = 0;
   int miscompares = 0;
   logic [FW-1:0] exp_frame;

   s_to_p #(.WIDTH(WIDTH), .N(N)) dut (
      .clk(clk), .reset(reset), .i_start(i_start), .i_valid(i_valid),
      .i_data(i_data), .i_frame_ack(i_frame_ack), .o_frame(o_frame),
      .o_frame_valid(o_frame_valid), .o_busy(o_busy), .o_overrun(o_overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus; inputs return to idle afterwards, outputs are sampled 1 ns after the edge.
   task automatic step(input int d, input logic v, input logic st, input logic ack, input logic rst);
      i_data      = WIDTH'(d);
      i_valid     = v;
      i_start     = st;
      i_frame_ack = ack;
      reset       = rst;
      @(posedge clk);
      #1;
      i_data = '0; i_valid = 0; i_start = 0; i_frame_ack = 0; reset = 0;
   endtask

   task automatic do_reset();
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
   endtask

   task automatic build_seq(input int base);
      for (int k = 0; k < N; k++)
         exp_frame[k*WIDTH +: WIDTH] = WIDTH'(base + k);
   endtask

   initial begin
      i_data = '0; i_valid = 0; i_start = 0; i_frame_ack = 0; reset = 1;
      #2;

      // Reset state
      do_reset();
      check("rst_frame", o_frame, '0);
      check("rst_valid", FW'(o_frame_valid), FW'(0));
      check("rst_busy", FW'(o_busy), FW'(0));
      check("rst_overrun", FW'(o_overrun), FW'(0));

      // Valid while IDLE is ignored
      for (int k = 0; k < 5; k++) step(900 + k, 1, 0, 0, 0);
      check("idle_busy", FW'(o_busy), FW'(0));

      // Scenario 1: back-to-back 0..63
      step(0, 0, 1, 0, 0);
      check("s1_busy", FW'(o_busy), FW'(1));
      for (int k = 0; k < N - 1; k++) step(k, 1, 0, 0, 0);
      check("s1_valid_before_last", FW'(o_frame_valid), FW'(0));
      step(N - 1, 1, 0, 0, 0);
      check("s1_valid", FW'(o_frame_valid), FW'(1));
      build_seq(0);
      check("s1_frame", o_frame, exp_frame);
      check("s1_busy_after", FW'(o_busy), FW'(1));

      // Scenario 2: next frame dropped while pending
      for (int k = 64; k < 128; k++) step(k, 1, 0, 0, 0);
      check("s2_overrun", FW'(o_overrun), FW'(1));
      check("s2_frame_kept", o_frame, exp_frame);
      check("s2_valid_kept", FW'(o_frame_valid), FW'(1));
      step(0, 0, 0, 1, 0);
      check("s2_ack_clears", FW'(o_frame_valid), FW'(0));
      step(0, 0, 0, 1, 0);
      check("s2_ack_idle_noeffect", FW'(o_frame_valid), FW'(0));
      check("s2_overrun_sticky", FW'(o_overrun), FW'(1));

      // Scenario 3: ack coincides with completion
      do_reset();
      check("s3_rst_overrun", FW'(o_overrun), FW'(0));
      step(0, 0, 1, 0, 0);
      for (int k = 0; k < 64; k++) step(k, 1, 0, 0, 0);
      for (int k = 64; k < 127; k++) step(k, 1, 0, 0, 0);
      step(127, 1, 0, 1, 0);
      build_seq(64);
      check("s3_frame", o_frame, exp_frame);
      check("s3_valid", FW'(o_frame_valid), FW'(1));
      check("s3_overrun", FW'(o_overrun), FW'(0));

      // Scenario 4: i_valid toggling with junk on idle cycles
      do_reset();
      step(0, 0, 1, 0, 0);
      for (int k = 0; k < N - 1; k++) begin
         step(k, 1, 0, 0, 0);
         step(999, 0, 0, 0, 0);
      end
      check("s4_valid_before_last", FW'(o_frame_valid), FW'(0));
      step(N - 1, 1, 0, 0, 0);
      check("s4_valid", FW'(o_frame_valid), FW'(1));
      build_seq(0);
      check("s4_frame", o_frame, exp_frame);

      // Scenario 5: i_start mid-frame together with sample 200
      do_reset();
      step(0, 0, 1, 0, 0);
      for (int k = 0; k < 10; k++) step(50 + k, 1, 0, 0, 0);
      step(200, 1, 1, 0, 0);
`ifdef S2P_ALIGN_EN
      for (int k = 201; k < 263; k++) step(k, 1, 0, 0, 0);
      check("s5_valid_before_last", FW'(o_frame_valid), FW'(0));
      step(263, 1, 0, 0, 0);
      build_seq(200);
      check("s5_valid", FW'(o_frame_valid), FW'(1));
      check("s5_slot0", FW'(o_frame[0 +: WIDTH]), FW'(200));
      check("s5_slot63", FW'(o_frame[63*WIDTH +: WIDTH]), FW'(263));
`else
      for (int k = 201; k < 253; k++) step(k, 1, 0, 0, 0);
      check("s5_valid_before_64th", FW'(o_frame_valid), FW'(0));
      for (int k = 253; k < 264; k++) step(k, 1, 0, 0, 0);
      for (int k = 0; k < 10; k++) exp_frame[k*WIDTH +: WIDTH] = WIDTH'(50 + k);
      for (int k = 10; k < N; k++) exp_frame[k*WIDTH +: WIDTH] = WIDTH'(190 + k);
      check("s5_valid", FW'(o_frame_valid), FW'(1));
      check("s5_slot0", FW'(o_frame[0 +: WIDTH]), FW'(50));
      check("s5_slot63", FW'(o_frame[63*WIDTH +: WIDTH]), FW'(253));
`endif
      check("s5_frame", o_frame, exp_frame);
      check("s5_overrun", FW'(o_overrun), FW'(0));

      // Scenario 6: reset mid-frame with a frame still pending, inputs active during reset
      for (int k = 0; k < 30; k++) step(300 + k, 1, 0, 0, 0);
      step(777, 1, 1, 1, 1);
      check("s6_rst_frame", o_frame, '0);
      check("s6_rst_valid", FW'(o_frame_valid), FW'(0));
      check("s6_rst_busy", FW'(o_busy), FW'(0));
      check("s6_rst_overrun", FW'(o_overrun), FW'(0));
      step(0, 0, 1, 0, 0);
      for (int k = 0; k < N; k++) step(400 + k, 1, 0, 0, 0);
      build_seq(400);
      check("s6_valid", FW'(o_frame_valid), FW'(1));
      check("s6_frame", o_frame, exp_frame);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/s_to_p.md
S_TO_P -- requirements
Module: s_to_p

Interface
REQ-001 Parameter WIDTH, default 10, bit width of each serial sample.
REQ-002 Parameter N, default 64, number of samples per frame.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_start  input  1  one-cycle request to begin frame collection.
REQ-006 i_valid  input  1  i_data holds a valid sample this cycle.
REQ-007 i_data  input  WIDTH  serial sample.
REQ-008 i_frame_ack  input  1  consumer accepts the presented frame.
REQ-009 o_frame  output  N*WIDTH  assembled frame; sample k at bits [k*WIDTH +: WIDTH].
REQ-010 o_frame_valid  output  1  o_frame holds an unacknowledged frame.
REQ-011 o_busy  output  1  high in FILL state.
REQ-012 o_overrun  output  1  sticky: a completed frame was dropped.

Function
REQ-013 The FSM SHALL have two states: IDLE and FILL.
REQ-014 IDLE SHALL ignore i_valid and move to FILL on i_start, with write index idx=0.
REQ-015 In FILL, each cycle with i_valid=1 SHALL write i_data into internal buffer slot idx and increment idx.
REQ-016 idx SHALL be ceil(log2(N)) bits and SHALL wrap from N-1 to 0.
REQ-017 The cycle that writes slot N-1 SHALL complete a frame.
REQ-018 On completion, the block SHALL copy the full buffer, including that sample, to o_frame at the same clock edge.
REQ-019 o_frame_valid SHALL be high from the cycle after that edge (latency 1 clock from the last sample).
REQ-020 After completion the FSM SHALL stay in FILL and collect the next frame continuously; no return to IDLE.
REQ-021 o_frame_valid SHALL stay high, and o_frame SHALL stay stable, until a cycle with i_frame_ack=1 clears o_frame_valid.
REQ-022 i_frame_ack while o_frame_valid=0 SHALL have no effect.
REQ-023 Completion with o_frame_valid=1 and i_frame_ack=0 SHALL drop the new frame, leave o_frame unchanged, and set o_overrun.
REQ-024 In that case idx SHALL still wrap to 0.
REQ-025 Completion in the same cycle as i_frame_ack SHALL load the new frame, keep o_frame_valid high, and not set o_overrun.
REQ-026 o_overrun SHALL clear only on reset.
REQ-027 Buffer slots not yet written in a partial frame SHALL retain their previous contents; only complete frames reach o_frame.

Reset
REQ-028 reset SHALL override all inputs in the same cycle.
REQ-029 On reset: state=IDLE, idx=0, o_frame=0, o_frame_valid=0, o_busy=0, o_overrun=0, buffer=0.
REQ-030 Reset mid-frame SHALL discard the partial frame and any pending o_frame_valid.

Configuration
REQ-031 Macro S2P_ALIGN_EN SHALL select the re-alignment feature.
REQ-032 With S2P_ALIGN_EN defined, i_start in FILL SHALL set idx to 0 and discard the partial frame.
REQ-033 With S2P_ALIGN_EN defined, if i_start and i_valid occur in the same cycle, i_data SHALL be written to slot 0 and idx SHALL become 1.
REQ-034 With S2P_ALIGN_EN defined, i_start during a completion cycle SHALL still deliver the completed frame.
REQ-035 Without S2P_ALIGN_EN, i_start SHALL be ignored in FILL.

Verification
REQ-036 Scenario 1: reset, i_start, then 64 valid samples 0..63 back-to-back -> o_frame_valid rises 1 cycle after sample 63; slot k == k; o_busy=1.
REQ-037 Scenario 2: with a frame pending and no ack, send the next 64 samples 64..127 -> o_overrun=1 and o_frame still holds 0..63; after ack, o_frame_valid=0.
REQ-038 Scenario 3: assert i_frame_ack in the same cycle as sample 127 completes its frame -> o_frame holds 64..127, o_frame_valid stays 1, o_overrun=0.
REQ-039 Scenario 4: send 64 samples with i_valid toggling 1,0,1,0 -> frame completes on the 64th valid sample only; slot k == k.
REQ-040 Scenario 5 (S2P_ALIGN_EN): send 10 samples, then i_start with sample 200, then 63 samples 201..263 -> slot 0 == 200, slot 63 == 263.
REQ-041 Scenario 5 (S2P_ALIGN_EN undefined): same stimulus -> the frame completes after 64 total valid samples and slot 0 holds the first sample sent.
REQ-042 Scenario 6: reset asserted after 30 samples, then i_start plus 64 samples -> all outputs zero during reset; the next frame holds only the post-reset samples.
